inst_prefetch_queue: RTL and testbench
======================================

# inst_prefetch_queue

Instruction prefetch stage between the instruction memory and the single-cycle core's decode (control_block/datapath). Issues sequential word fetches over a single-outstanding req/ack memory port, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode over a valid/ready handshake. A redirect input, driven by the core on taken branch or jump, flushes buffered and in-flight instructions and restarts fetch at a new PC.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  rising-edge clock, sole clock domain
- reset  in  1  asynchronous, active-low; 0 = in reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  byte address of requested word; bits [1:0] always 0
- imem_ack  in  1  rdata valid this cycle; meaningful only while imem_req=1
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced to 0
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_code  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- inst_pc  out  32  PC of head instruction; 0 when empty
- fifo_count  out  $clog2(DEPTH)+1  entries held

## Operation
- State machine IDLE / WAIT / DROP.
  - IDLE: imem_req=0. Go WAIT (req=1, addr=fetch_pc) when count_next < DEPTH.
  - WAIT: req and addr held stable until ack. On ack without redirect: push {imem_rdata, imem_addr}; fetch_pc += 4; stay WAIT with new address if count_next < DEPTH, else IDLE.
  - DROP: request in flight belongs to a flushed stream; req/addr held until ack; ack data discarded; then WAIT at fetch_pc (space always available, FIFO empty) or IDLE.
- count_next = count + push − pop; pop = inst_valid & inst_ready.
- Redirect (any state): FIFO cleared, fetch_pc <= {redirect_pc[31:2],2'b00}. WAIT without ack → DROP. WAIT with ack same cycle → ack dropped, go WAIT at new PC. DROP with ack same cycle → WAIT at new PC. DROP without ack → stay DROP with updated fetch_pc. IDLE → WAIT at new PC.
- Redirect beats push and pop in the same cycle: FIFO empty next cycle, popped head is still considered consumed by decode.
- Push and pop in same cycle with FIFO full is impossible (no request issued when full).
- fetch_pc wraps 32'hFFFF_FFFC → 0; read/write pointers wrap modulo DEPTH.
- ack while imem_req=0 ignored.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst_code NOP, inst_pc 0, fifo_count 0, state IDLE, fetch_pc RESET_PC.
- First edge after reset release: imem_req=1, imem_addr=RESET_PC.
- Ack in cycle N → entry visible (inst_valid=1) in cycle N+1; next request addr visible N+1.
- Zero-wait memory (ack in same cycle as req): sustained 1 instruction/cycle while decode ready.
- inst_code/inst_pc combinational from FIFO head; no added latency on pop.
- Redirect in cycle N → inst_valid=0 in N+1; new-PC request visible N+1 unless DROP.
- Reset asserted mid-transfer: all state cleared immediately; memory must abandon the request.

## Structure
- Shared header fetch_defs.vh: XLEN=32, INST_NOP=32'h0000_0013, state encodings FS_IDLE/FS_WAIT/FS_DROP.
- One sub-module: fetch_fifo (parameter DEPTH, WIDTH=64; push/pop/flush, full/empty/count, combinational head read).
- Top holds FSM, fetch_pc, and redirect logic.

## Test plan
- Reset release, memory acks same cycle, inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles from cycle 2; fifo_count ≤1.
- inst_ready=0, zero-wait memory -> exactly 4 acks, fifo_count=4, imem_req=0; raise ready -> req reasserts with addr 16 the cycle after first pop.
- Memory 3-cycle ack latency -> imem_addr stable across wait cycles; inst_valid one cycle after each ack.
- Redirect to 32'h0000_0103 while WAIT on addr 8, ack 2 cycles later -> that ack discarded, next req addr 32'h100, first inst_pc 32'h100.
- Redirect coincident with ack and pop -> next cycle inst_valid=0, fifo_count=0, req addr=redirect PC.
- RESET_PC=32'hFFFF_FFF8, 3 fetches -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; reset pulsed mid-WAIT -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
// Covers data widths, the NOP encoding and the fetch FSM state type.
package inst_prefetch_queue_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_WAIT = 2'd1,
      FS_DROP = 2'd2
   } fetch_state_t;

   // Fetch addresses are always word aligned; low bits of any incoming PC are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_prefetch_queue_fetch_fifo.sv
// Small circular FIFO holding {instruction, pc} pairs for the prefetch queue.
// The head is read combinationally, and flush overrides any push or pop in the same cycle.
module inst_prefetch_queue_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign head_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage: sequential single-outstanding fetches into a FIFO,
// presented to decode with valid/ready, flushed and restarted on redirect.
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int         CW       = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   output logic          imem_req,
   output logic [31:0]   imem_addr,
   input  logic          imem_ack,
   input  logic [31:0]   imem_rdata,
   input  logic          redirect_valid,
   input  logic [31:0]   redirect_pc,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [31:0]   inst_code,
   output logic [31:0]   inst_pc,
   output logic [CW-1:0] fifo_count
);

   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_d;
   logic          req_d;
   logic [31:0]   redirect_target;
   logic          ack;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [63:0]   head_data;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          has_space;

   inst_prefetch_queue_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({imem_rdata, imem_addr}),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   assign inst_valid = ~fifo_empty;
   assign inst_code  = fifo_empty ? INST_NOP : head_data[63:32];
   assign inst_pc    = fifo_empty ? 32'h0    : head_data[31:0];
   assign fifo_count = count;

   // Handshake decode plus the occupancy the FIFO will have after this edge.
   always_comb begin
      redirect_target = word_align(redirect_pc);
      ack             = imem_ack & imem_req;
      pop             = inst_valid & inst_ready;
      push            = (state_q == FS_WAIT) & ack & ~redirect_valid & ~fifo_full;
      count_next      = count;
      if (redirect_valid) begin
         count_next = '0;
      end else begin
         if (push)
            count_next = count_next + CW'(1);
         if (pop)
            count_next = count_next - CW'(1);
      end
      has_space = (count_next < DEPTH_CNT);
   end

   // A request in flight is never abandoned: redirect during WAIT parks in DROP
   // until the stale ack arrives, with fetch_pc already pointing at the new stream.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = imem_addr;
      case (state_q)
         FS_IDLE: begin
            if (redirect_valid) begin
               state_d    = FS_WAIT;
               fetch_pc_d = redirect_target;
               addr_d     = redirect_target;
            end else if (has_space) begin
               state_d = FS_WAIT;
               addr_d  = fetch_pc_q;
            end
         end
         FS_WAIT: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_target;
               if (ack) begin
                  addr_d = redirect_target;
               end else begin
                  state_d = FS_DROP;
               end
            end else if (ack) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (has_space)
                  addr_d = fetch_pc_q + 32'd4;
               else
                  state_d = FS_IDLE;
            end
         end
         FS_DROP: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_target;
               if (ack) begin
                  state_d = FS_WAIT;
                  addr_d  = redirect_target;
               end
            end else if (ack) begin
               if (has_space) begin
                  state_d = FS_WAIT;
                  addr_d  = fetch_pc_q;
               end else begin
                  state_d = FS_IDLE;
               end
            end
         end
         default: state_d = FS_IDLE;
      endcase
      req_d = (state_d != FS_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FS_IDLE;
         fetch_pc_q <= RESET_PC;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         imem_req   <= req_d;
         imem_addr  <= addr_d;
      end
   end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue.
// The main instance uses RESET_PC=0, and a second instance checks fetch_pc wrap from 32'hFFFF_FFF8.
module tb_inst_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        reset2;
   logic        ack_manual;
   logic        zero_wait;
   logic        ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_code;
   logic [31:0] inst_pc;
   logic [2:0]  fifo_count;

   logic        req2;
   logic [31:0] addr2;
   logic        valid2;
   logic [31:0] code2;
   logic [31:0] pc2;
   logic [2:0]  count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_ack   = zero_wait ? imem_req : ack_manual;
   assign imem_rdata = imem_addr + 32'h1000_0000;

   inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (ready),
      .inst_code      (inst_code),
      .inst_pc        (inst_pc),
      .fifo_count     (fifo_count)
   );

   inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk            (clk),
      .reset          (reset2),
      .imem_req       (req2),
      .imem_addr      (addr2),
      .imem_ack       (req2),
      .imem_rdata     (addr2),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .inst_valid     (valid2),
      .inst_ready     (1'b1),
      .inst_code      (code2),
      .inst_pc        (pc2),
      .fifo_count     (count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      reset2      = 1'b0;
      ack_manual  = 1'b0;
      zero_wait   = 1'b0;
      ready       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      tick();
      tick();

      $display("[TB] reset values");
      check_output("rst_req",   32'(imem_req),   32'h0);
      check_output("rst_addr",  imem_addr,       32'h0);
      check_output("rst_valid", 32'(inst_valid), 32'h0);
      check_output("rst_code",  inst_code,       32'h0000_0013);
      check_output("rst_pc",    inst_pc,         32'h0);
      check_output("rst_count", 32'(fifo_count), 32'h0);

      $display("[TB] zero-wait streaming");
      zero_wait = 1'b1;
      ready     = 1'b1;
      reset     = 1'b1;
      tick();
      check_output("stream_req",  32'(imem_req), 32'h1);
      check_output("stream_addr", imem_addr,     32'h0);
      tick();
      check_output("stream_valid0", 32'(inst_valid), 32'h1);
      check_output("stream_pc0",    inst_pc,          32'h0);
      check_output("stream_code0",  inst_code,        32'h1000_0000);
      check_output("stream_cnt0",   32'(fifo_count),  32'h1);
      for (int i = 1; i < 4; i++) begin
         tick();
         check_output("stream_pc",  inst_pc,         32'(i * 4));
         check_output("stream_cnt", 32'(fifo_count), 32'h1);
      end

      $display("[TB] fill with decode stalled");
      ready = 1'b0;
      apply_reset();
      repeat (5) tick();
      check_output("fill_count", 32'(fifo_count), 32'h4);
      check_output("fill_req",   32'(imem_req),   32'h0);
      check_output("fill_pc",    inst_pc,         32'h0);
      tick();
      check_output("fill_count_hold", 32'(fifo_count), 32'h4);
      check_output("fill_req_hold",   32'(imem_req),   32'h0);
      ready = 1'b1;
      tick();
      check_output("refill_req",   32'(imem_req),   32'h1);
      check_output("refill_addr",  imem_addr,       32'h10);
      check_output("refill_count", 32'(fifo_count), 32'h3);
      check_output("refill_pc",    inst_pc,         32'h4);
      ready     = 1'b0;
      zero_wait = 1'b0;

      $display("[TB] three-cycle memory latency");
      apply_reset();
      tick();
      check_output("lat_req1",   32'(imem_req),   32'h1);
      check_output("lat_addr1",  imem_addr,       32'h0);
      tick();
      check_output("lat_addr2",  imem_addr,       32'h0);
      tick();
      check_output("lat_addr3",  imem_addr,       32'h0);
      check_output("lat_valid3", 32'(inst_valid), 32'h0);
      ack_manual = 1'b1;
      tick();
      ack_manual = 1'b0;
      check_output("lat_valid4", 32'(inst_valid), 32'h1);
      check_output("lat_pc4",    inst_pc,         32'h0);
      check_output("lat_addr4",  imem_addr,       32'h4);
      check_output("lat_count4", 32'(fifo_count), 32'h1);
      ack_manual = 1'b1;
      tick();
      ack_manual = 1'b0;
      check_output("lat_count5", 32'(fifo_count), 32'h2);
      check_output("lat_addr5",  imem_addr,       32'h8);

      $display("[TB] redirect while waiting on addr 8");
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      check_output("drop_valid", 32'(inst_valid), 32'h0);
      check_output("drop_count", 32'(fifo_count), 32'h0);
      check_output("drop_req",   32'(imem_req),   32'h1);
      check_output("drop_addr",  imem_addr,       32'h8);
      tick();
      ack_manual = 1'b1;
      tick();
      ack_manual = 1'b0;
      check_output("drop_newaddr", imem_addr,       32'h100);
      check_output("drop_newreq",  32'(imem_req),   32'h1);
      check_output("drop_discard", 32'(inst_valid), 32'h0);
      ack_manual = 1'b1;
      tick();
      ack_manual = 1'b0;
      check_output("redir_valid", 32'(inst_valid), 32'h1);
      check_output("redir_pc",    inst_pc,         32'h100);
      check_output("redir_code",  inst_code,       32'h1000_0100);
      check_output("redir_count", 32'(fifo_count), 32'h1);

      $display("[TB] redirect with ack and pop together");
      ready       = 1'b1;
      ack_manual  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      ready      = 1'b0;
      ack_manual = 1'b0;
      redirect   = 1'b0;
      check_output("coin_valid", 32'(inst_valid), 32'h0);
      check_output("coin_count", 32'(fifo_count), 32'h0);
      check_output("coin_req",   32'(imem_req),   32'h1);
      check_output("coin_addr",  imem_addr,       32'h200);
      check_output("coin_code",  inst_code,       32'h0000_0013);

      $display("[TB] asynchronous reset mid-wait");
      #3;
      reset = 1'b0;
      #1;
      check_output("areset_req",   32'(imem_req),   32'h0);
      check_output("areset_addr",  imem_addr,       32'h0);
      check_output("areset_count", 32'(fifo_count), 32'h0);

      $display("[TB] fetch_pc wrap");
      tick();
      reset2 = 1'b1;
      tick();
      check_output("wrap_req1",  32'(req2), 32'h1);
      check_output("wrap_addr1", addr2,     32'hFFFF_FFF8);
      tick();
      check_output("wrap_addr2", addr2,     32'hFFFF_FFFC);
      check_output("wrap_pc2",   pc2,       32'hFFFF_FFF8);
      check_output("wrap_code2", code2,     32'hFFFF_FFF8);
      tick();
      check_output("wrap_addr3",  addr2,       32'h0);
      check_output("wrap_pc3",    pc2,         32'hFFFF_FFFC);
      check_output("wrap_count3", 32'(count2), 32'h1);
      #2;
      reset2 = 1'b0;
      #1;
      check_output("wrap_rst_req",   32'(req2),   32'h0);
      check_output("wrap_rst_addr",  addr2,       32'hFFFF_FFF8);
      check_output("wrap_rst_valid", 32'(valid2), 32'h0);
      check_output("wrap_rst_count", 32'(count2), 32'h0);
      check_output("wrap_rst_pc",    pc2,         32'h0);
      check_output("wrap_rst_code",  code2,       32'h0000_0013);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
